// File: rtl/std_cache_pkg.sv
// Shared types for the std cache bypass responder: request/response structs,
// AMO opcodes and the bypass FSM encoding.
package std_cache_pkg;

    localparam int BYPASS_BEAT_BYTES = 8;
    localparam int BYPASS_ID_W       = 4;
    localparam int BYPASS_ADDR_W     = 64;
    localparam int BYPASS_DATA_W     = 64;

    typedef enum logic [3:0] {
        AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND,
        AMO_OR, AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU
    } amo_t;

    typedef enum logic [2:0] {
        IDLE, MEM_REQ, MEM_WAIT, AMO_WR, RESP
    } bypass_fsm_e;

    typedef struct packed {
        logic                         req;
        logic [1:0]                   reqtype;
        amo_t                         amo;
        logic [BYPASS_ID_W-1:0]       id;
        logic [BYPASS_ADDR_W-1:0]     addr;
        logic [BYPASS_DATA_W-1:0]     wdata;
        logic                         we;
        logic [BYPASS_BEAT_BYTES-1:0] be;
        logic [1:0]                   size;
    } bypass_req_t;

    typedef struct packed {
        logic                     gnt;
        logic                     valid;
        logic [BYPASS_DATA_W-1:0] rdata;
    } bypass_rsp_t;

    // LR/SC are plain read/write beats; everything else needs read-modify-write.
    function automatic logic is_rmw_amo(amo_t op);
        return !(op inside {AMO_NONE, AMO_LR, AMO_SC});
    endfunction

endpackage

// File: rtl/std_cache_bypass_amo_alu.sv
// Combinational AMO datapath: merges the op result into the selected 32-bit
// lane (size 2'b10) or the full 64-bit beat.
module std_cache_bypass_amo_alu
    import std_cache_pkg::*;
(
    input  amo_t        i_op,
    input  logic [1:0]  i_size,
    input  logic        i_lane,
    input  logic [63:0] i_old,
    input  logic [63:0] i_operand,
    output logic [63:0] o_new
);

    logic        w_word;
    logic [31:0] w_a32;
    logic [63:0] w_a_s, w_b_s, w_a_u, w_b_u, w_res;
    logic        w_lt_s, w_lt_u;

    assign w_word = (i_size == 2'b10);
    assign w_a32  = i_lane ? i_old[63:32] : i_old[31:0];
    // Word operand is register-form (low 32 bits), independent of lane.
    assign w_a_s  = w_word ? {{32{w_a32[31]}}, w_a32} : i_old;
    assign w_b_s  = w_word ? {{32{i_operand[31]}}, i_operand[31:0]} : i_operand;
    assign w_a_u  = w_word ? {32'b0, w_a32} : i_old;
    assign w_b_u  = w_word ? {32'b0, i_operand[31:0]} : i_operand;
    assign w_lt_s = $signed(w_a_s) < $signed(w_b_s);
    assign w_lt_u = w_a_u < w_b_u;

    always_comb begin
        w_res = w_b_u;
        case (i_op)
            AMO_ADD:  w_res = w_a_u + w_b_u;
            AMO_AND:  w_res = w_a_u & w_b_u;
            AMO_OR:   w_res = w_a_u | w_b_u;
            AMO_XOR:  w_res = w_a_u ^ w_b_u;
            AMO_MAX:  w_res = w_lt_s ? w_b_u : w_a_u;
            AMO_MAXU: w_res = w_lt_u ? w_b_u : w_a_u;
            AMO_MIN:  w_res = w_lt_s ? w_a_u : w_b_u;
            AMO_MINU: w_res = w_lt_u ? w_a_u : w_b_u;
            default:  w_res = w_b_u;
        endcase
    end

    assign o_new = !w_word ? w_res :
                   i_lane  ? {w_res[31:0], i_old[31:0]} : {i_old[63:32], w_res[31:0]};

endmodule

// File: rtl/std_cache_bypass_responder.sv
// Single-outstanding bypass port terminator: one bypass request -> one memory
// beat -> one response. Define STD_CACHE_BYPASS_AMO_EN for read-modify-write AMOs.
module std_cache_bypass_responder
    import std_cache_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  bypass_req_t                  bypass_req_i,
    output bypass_rsp_t                  bypass_rsp_o,
    output logic                         mem_req_o,
    input  logic                         mem_gnt_i,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic                         mem_we_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    output logic [BYPASS_BEAT_BYTES-1:0] mem_be_o,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_W-1:0]            mem_rdata_i
);

    bypass_fsm_e                  r_state;
    logic [ADDR_W-1:0]            r_addr;
    logic                         r_we;
    logic [DATA_W-1:0]            r_wdata;
    logic [BYPASS_BEAT_BYTES-1:0] r_be;
    logic [DATA_W-1:0]            r_rdata;
    logic                         w_accept;

    logic [ID_W-1:0] w_unused_id;
    logic            w_unused;
    assign w_unused_id = bypass_req_i.id;
    assign w_unused    = ^{bypass_req_i.reqtype, bypass_req_i.amo, bypass_req_i.size,
                           bypass_req_i.addr[2:0]};

    assign w_accept = !rst_i && (r_state == IDLE) && bypass_req_i.req;

`ifdef STD_CACHE_BYPASS_AMO_EN
    amo_t              r_amo;
    logic [1:0]        r_size;
    logic              r_lane;
    logic              r_wr_gnt;
    logic [31:0]       w_old_lane;
    logic [DATA_W-1:0] w_amo_old, w_amo_new;

    std_cache_bypass_amo_alu u_alu (
        .i_op      (r_amo),
        .i_size    (r_size),
        .i_lane    (r_lane),
        .i_old     (mem_rdata_i),
        .i_operand (r_wdata),
        .o_new     (w_amo_new)
    );

    assign w_old_lane = r_lane ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    assign w_amo_old  = (r_size == 2'b10) ? {{32{w_old_lane[31]}}, w_old_lane} : mem_rdata_i;
    assign mem_req_o  = (r_state == MEM_REQ) || ((r_state == AMO_WR) && !r_wr_gnt);
`else
    assign mem_req_o  = (r_state == MEM_REQ);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
`ifdef STD_CACHE_BYPASS_AMO_EN
            r_amo    <= AMO_NONE;
            r_size   <= 2'b00;
            r_lane   <= 1'b0;
            r_wr_gnt <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_addr  <= {bypass_req_i.addr[ADDR_W-1:3], 3'b000};
                    r_wdata <= bypass_req_i.wdata[DATA_W-1:0];
                    r_be    <= bypass_req_i.be;
`ifdef STD_CACHE_BYPASS_AMO_EN
                    r_we    <= bypass_req_i.we && !is_rmw_amo(bypass_req_i.amo);
                    r_amo   <= bypass_req_i.amo;
                    r_size  <= bypass_req_i.size;
                    r_lane  <= bypass_req_i.addr[2];
`else
                    r_we    <= bypass_req_i.we;
`endif
                    r_state <= MEM_REQ;
                end
                MEM_REQ: if (mem_gnt_i) r_state <= MEM_WAIT;
                MEM_WAIT: if (mem_rvalid_i) begin
                    r_rdata <= r_we ? '0 : mem_rdata_i;
                    r_state <= RESP;
`ifdef STD_CACHE_BYPASS_AMO_EN
                    // Read half of an RMW: keep the old value, turn the beat into a write.
                    if (is_rmw_amo(r_amo)) begin
                        r_rdata  <= w_amo_old;
                        r_we     <= 1'b1;
                        r_wdata  <= w_amo_new;
                        r_wr_gnt <= 1'b0;
                        r_state  <= AMO_WR;
                    end
`endif
                end
`ifdef STD_CACHE_BYPASS_AMO_EN
                AMO_WR: begin
                    if (!r_wr_gnt) begin
                        if (mem_gnt_i) r_wr_gnt <= 1'b1;
                    end else if (mem_rvalid_i) begin
                        r_state <= RESP;
                    end
                end
`endif
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bypass_rsp_o       = '0;
        bypass_rsp_o.gnt   = w_accept;
        bypass_rsp_o.valid = (r_state == RESP);
        bypass_rsp_o.rdata = r_rdata;
    end

    assign mem_addr_o  = r_addr;
    assign mem_we_o    = r_we;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;

endmodule
